// File: rtl/uart_cmd_write_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_write_rx_if: byte-stream, control-unit and BRAM write-port bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_cmd_write_rx_if #(
  parameter int NUM_ELEMENTOS = 1024,
  parameter int ELEM_BYTES    = 1
);
  localparam int ADDR_W = (NUM_ELEMENTOS > 1) ? $clog2(NUM_ELEMENTOS) : 1;
  localparam int ELEM_W = 8 * ELEM_BYTES;

  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              begin_write;
  logic [7:0]        command;
  logic              command_ready;
  logic              mem_we_a;
  logic              mem_we_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              write_done;
  logic              write_error;
  logic              busy;

  modport master (
    output rx_data, rx_ready, begin_write,
    input  command, command_ready, mem_we_a, mem_we_b, mem_addr, mem_wdata,
           write_done, write_error, busy
  );

  modport slave (
    input  rx_data, rx_ready, begin_write,
    output command, command_ready, mem_we_a, mem_we_b, mem_addr, mem_wdata,
           write_done, write_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_write_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_write_rx: decodes UART command bytes and streams WRITE data into vector memory A or B.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_cmd_write_rx #(
  parameter int NUM_ELEMENTOS  = 1024,
  parameter int ELEM_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  uart_cmd_write_rx_if.slave bus
);
  localparam int ADDR_W = (NUM_ELEMENTOS > 1) ? $clog2(NUM_ELEMENTOS) : 1;
  localparam int ELEM_W = 8 * ELEM_BYTES;
  localparam int BCNT_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(ELEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(NUM_ELEMENTOS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [7:0]        command_q;
  logic              command_ready_q;
  logic              mem_we_a_q;
  logic              mem_we_b_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ELEM_W-1:0] mem_wdata_q;
  logic              write_done_q;
  logic              write_error_q;

  logic              mem_sel;
  logic              begin_seen;
  logic [ADDR_W-1:0] elem_cnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [ELEM_W-1:0] asm_q;
  logic [ELEM_W-1:0] asm_next;

  logic              cmd_load;
  logic              start;
  logic              take_byte;
  logic              elem_done;
  logic              finish;
  logic              abort;
  logic              timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_load   = 1'b0;
    start      = 1'b0;
    take_byte  = 1'b0;
    elem_done  = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_ready && (bus.rx_data != 8'h00)) begin
          cmd_load = 1'b1;
          if (bus.rx_data[0]) begin
            start      = 1'b1;
            state_next = RECV;
          end
        end
      end
      RECV: begin
        // A received byte always wins over a timeout expiring in the same cycle.
        if (bus.rx_ready) begin
          take_byte = 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            elem_done = 1'b1;
            if (elem_cnt == LAST_ELEM) begin
              state_next = DONE;
            end
          end
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        if (begin_seen || bus.begin_write) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < ELEM_BYTES; i++) begin
      if (byte_cnt == BCNT_W'(i)) begin
        asm_next[i*8 +: 8] = bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      command_q       <= 8'h00;
      command_ready_q <= 1'b0;
      mem_we_a_q      <= 1'b0;
      mem_we_b_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      write_done_q    <= 1'b0;
      write_error_q   <= 1'b0;
      mem_sel         <= 1'b0;
      begin_seen      <= 1'b0;
      elem_cnt        <= '0;
      byte_cnt        <= '0;
      asm_q           <= '0;
    end else begin
      command_ready_q <= cmd_load;
      mem_we_a_q      <= elem_done && !mem_sel;
      mem_we_b_q      <= elem_done && mem_sel;
      write_done_q    <= finish || abort;
      write_error_q   <= abort;

      if (cmd_load) begin
        command_q <= bus.rx_data;
      end

      if (start) begin
        mem_sel  <= bus.rx_data[7];
        elem_cnt <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
      end

      if (take_byte) begin
        asm_q <= asm_next;
        if (elem_done) begin
          byte_cnt    <= '0;
          elem_cnt    <= elem_cnt + 1'b1;
          mem_addr_q  <= elem_cnt;
          mem_wdata_q <= asm_next;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end

      // begin_write may rise before, during or after the data stream.
      if (start || finish || abort) begin
        begin_seen <= 1'b0;
      end else if (((state == RECV) || (state == DONE)) && bus.begin_write) begin
        begin_seen <= 1'b1;
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
      logic [TO_W-1:0] to_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          to_cnt <= '0;
        end else if (start || bus.rx_ready || (state != RECV)) begin
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      // Decision is one cycle ahead so the registered write_done lands
      // exactly TIMEOUT_CYCLES after the last received byte.
      assign timeout_hit = (state == RECV) && ((32'(to_cnt) + 32'd2) >= TO_LIMIT);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign bus.command       = command_q;
  assign bus.command_ready = command_ready_q;
  assign bus.mem_we_a      = mem_we_a_q;
  assign bus.mem_we_b      = mem_we_b_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.write_done    = write_done_q;
  assign bus.write_error   = write_error_q;
  assign bus.busy          = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_write_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_write_rx: directed, table-driven bench for uart_cmd_write_rx.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_write_rx;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_write_rx_if #(.NUM_ELEMENTOS(4), .ELEM_BYTES(2)) bus ();

  uart_cmd_write_rx #(
    .NUM_ELEMENTOS (4),
    .ELEM_BYTES    (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       exp_pulse;
    logic [7:0] exp_cmd;
  } cmd_vec_t;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } elem_t;

  typedef struct {
    int is_b;
    int both;
    int addr;
    int data;
    int cyc;
  } we_rec_t;

  cmd_vec_t cmd_vecs[6];
  elem_t    elems[4];
  we_rec_t  we_log[$];
  int       hi_cyc[4];
  int       rx_cyc;
  int       done_cnt = 0, err_cnt = 0, last_done_cyc = -1;
  int       clash = 0, lone_err = 0;

  always @(negedge clk) begin
    we_rec_t r;
    if (bus.mem_we_a || bus.mem_we_b) begin
      r.is_b = int'(bus.mem_we_b);
      r.both = int'(bus.mem_we_a && bus.mem_we_b);
      r.addr = int'(bus.mem_addr);
      r.data = int'(bus.mem_wdata);
      r.cyc  = cyc;
      we_log.push_back(r);
    end
    if (bus.write_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (bus.write_error) err_cnt++;
    end
    if (bus.write_error && !bus.write_done) lone_err++;
    if (bus.write_done && bus.command_ready) clash++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; holds rx_ready for exactly one cycle.
  task automatic strobe(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    rx_cyc       = cyc;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic run_write(input logic [7:0] cmd, input bit burst);
    strobe(cmd);
    for (int e = 0; e < 4; e++) begin
      strobe(elems[e].lo);
      strobe(elems[e].hi);
      hi_cyc[e] = rx_cyc;
      if (!burst) idle(2);
    end
  endtask

  task automatic check_writes(input string tag, input int n0, input int exp_b);
    check({tag, "_we_count"}, we_log.size() - n0, 4);
    for (int e = 0; e < 4; e++) begin
      if (n0 + e < we_log.size()) begin
        check({tag, "_we_sel"},  we_log[n0+e].is_b, exp_b);
        check({tag, "_we_both"}, we_log[n0+e].both, 0);
        check({tag, "_we_addr"}, we_log[n0+e].addr, e);
        check({tag, "_we_data"}, we_log[n0+e].data, int'(elems[e].exp));
        check({tag, "_we_lat"},  we_log[n0+e].cyc,  hi_cyc[e] + 1);
      end
    end
  endtask

  initial begin
    int n0, d0, e0, t3, bw;

    cmd_vecs[0] = '{8'h04, 1'b1, 8'h04};
    cmd_vecs[1] = '{8'h00, 1'b0, 8'h04};
    cmd_vecs[2] = '{8'h02, 1'b1, 8'h02};
    cmd_vecs[3] = '{8'h80, 1'b1, 8'h80};
    cmd_vecs[4] = '{8'h00, 1'b0, 8'h80};
    cmd_vecs[5] = '{8'hFE, 1'b1, 8'hFE};
    elems[0] = '{8'h34, 8'h12, 16'h1234};
    elems[1] = '{8'h78, 8'h56, 16'h5678};
    elems[2] = '{8'hBC, 8'h9A, 16'h9ABC};
    elems[3] = '{8'hF0, 8'hDE, 16'hDEF0};

    reset = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_ready = 1'b0;
    bus.begin_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_command", int'(bus.command), 0);
    check("rst_cmd_ready", int'(bus.command_ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_we", int'(bus.mem_we_a | bus.mem_we_b), 0);
    check("rst_done_err", int'(bus.write_done | bus.write_error), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_wdata", int'(bus.mem_wdata), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Command decode in IDLE, including ignored 0x00 bytes
    for (int i = 0; i < 6; i++) begin
      strobe(cmd_vecs[i].b);
      @(negedge clk);
      check("cmd_pulse", int'(bus.command_ready), int'(cmd_vecs[i].exp_pulse));
      check("cmd_value", int'(bus.command), int'(cmd_vecs[i].exp_cmd));
      check("cmd_busy", int'(bus.busy), 0);
      @(negedge clk);
      check("cmd_pulse_width", int'(bus.command_ready), 0);
      @(posedge clk);
      #1;
    end
    check("cmd_no_we", we_log.size(), 0);

    // WRITE to A with begin_write held high, spaced bytes
    bus.begin_write = 1'b1;
    n0 = we_log.size();
    d0 = done_cnt;
    e0 = err_cnt;
    run_write(8'h01, 1'b0);
    idle(3);
    check_writes("wr_a", n0, 0);
    check("wr_a_done_cnt", done_cnt - d0, 1);
    check("wr_a_done_lat", last_done_cyc, hi_cyc[3] + 2);
    check("wr_a_err", err_cnt - e0, 0);
    check("wr_a_command", int'(bus.command), 8'h01);

    // WRITE to B with back-to-back bytes overlapping the we pulses
    n0 = we_log.size();
    d0 = done_cnt;
    run_write(8'h81, 1'b1);
    idle(3);
    check_writes("wr_b", n0, 1);
    check("wr_b_done_cnt", done_cnt - d0, 1);
    check("wr_b_done_lat", last_done_cyc, hi_cyc[3] + 2);
    check("wr_b_command", int'(bus.command), 8'h81);

    // Timeout after 3 data bytes
    n0 = we_log.size();
    d0 = done_cnt;
    e0 = err_cnt;
    strobe(8'h01);
    strobe(8'h34);
    strobe(8'h12);
    strobe(8'h78);
    t3 = rx_cyc;
    idle(110);
    check("to_we_count", we_log.size() - n0, 1);
    if (we_log.size() > n0) begin
      check("to_we_addr", we_log[n0].addr, 0);
      check("to_we_data", we_log[n0].data, 16'h1234);
    end
    check("to_done_cnt", done_cnt - d0, 1);
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_done_lat", last_done_cyc, t3 + 100);
    check("to_busy", int'(bus.busy), 0);
    strobe(8'h02);
    @(negedge clk);
    check("to_next_pulse", int'(bus.command_ready), 1);
    check("to_next_cmd", int'(bus.command), 8'h02);
    @(posedge clk);
    #1 bus.begin_write = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of RECV
    d0 = done_cnt;
    strobe(8'h01);
    strobe(8'h34);
    strobe(8'h12);
    strobe(8'h78);
    strobe(8'h56);
    idle(2);
    check("mid_busy_pre", int'(bus.busy), 1);
    check("mid_addr_pre", int'(bus.mem_addr), 1);
    check("mid_wdata_pre", int'(bus.mem_wdata), 16'h5678);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_command", int'(bus.command), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_addr", int'(bus.mem_addr), 0);
    check("mid_rst_wdata", int'(bus.mem_wdata), 0);
    check("mid_rst_flags", int'({bus.mem_we_a, bus.mem_we_b, bus.write_done,
                                 bus.write_error, bus.command_ready}), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);
    n0 = we_log.size();
    strobe(8'h08);
    @(negedge clk);
    check("post_rst_pulse", int'(bus.command_ready), 1);
    check("post_rst_cmd", int'(bus.command), 8'h08);
    @(posedge clk);
    #1;
    idle(3);
    check("post_rst_no_we", we_log.size() - n0, 0);
    check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_no_done", done_cnt - d0, 0);

    // DONE waits for a late begin_write
    n0 = we_log.size();
    d0 = done_cnt;
    e0 = err_cnt;
    run_write(8'h01, 1'b0);
    idle(50);
    check("late_we_count", we_log.size() - n0, 4);
    check("late_wait_done", done_cnt - d0, 0);
    check("late_wait_busy", int'(bus.busy), 1);
    bus.begin_write = 1'b1;
    bw = cyc;
    idle(3);
    check("late_done_cnt", done_cnt - d0, 1);
    check("late_done_lat", last_done_cyc, bw + 1);
    check("late_err", err_cnt - e0, 0);
    check("late_busy", int'(bus.busy), 0);
    bus.begin_write = 1'b0;
    idle(2);

    check("no_done_cmd_clash", clash, 0);
    check("no_lone_error", lone_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_cmd_write_rx.md
Name: uart_cmd_write_rx

Overview:
- Receive-side counterpart of the pipeline control unit.
- Consumes the byte stream from the UART receiver and decodes the first byte of each transaction as a command. It presents that command with a `command_ready` pulse.
- For WRITE commands it answers the control unit's `begin_write` request. It assembles `NUM_ELEMENTOS` incoming elements, writes them into vector memory A or B, and then pulses `write_done`.
- Sits between `uart_rx` and the control unit / BRAM write ports.

Parameters:
- `NUM_ELEMENTOS`, 1024: number of elements per vector write.
- `ELEM_BYTES`, 1: bytes per element. Element width is 8*`ELEM_BYTES`; elements are assembled little-endian, first byte is LSB.
- `TIMEOUT_CYCLES`, 0: clock cycles of rx silence inside a write before it is aborted. 0 disables the timeout.

Ports:
- `clk`  in  1  100 MHz clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid when `rx_ready`=1.
- `rx_ready`  in  1  one-cycle strobe per received byte.
- `begin_write`  in  1  level from control unit; high while it waits in WRITE.
- `command`  out  8  last decoded command byte; held until the next command.
- `command_ready`  out  1  one-cycle pulse when `command` updates.
- `mem_we_a`  out  1  write enable, vector memory A.
- `mem_we_b`  out  1  write enable, vector memory B.
- `mem_addr`  out  clog2(`NUM_ELEMENTOS`)  element write address.
- `mem_wdata`  out  8*`ELEM_BYTES`  assembled element.
- `write_done`  out  1  one-cycle pulse; write transaction finished (normal or aborted).
- `write_error`  out  1  one-cycle pulse coincident with `write_done` on timeout abort.
- `busy`  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`reset`=0, asynchronous): state IDLE; all outputs 0; `command`=0x00; element, byte and timeout counters cleared; `begin_seen` flag cleared.
- States: IDLE, RECV, DONE.
- IDLE, on `rx_ready` with `rx_data`≠0x00:
  - Latch `rx_data` into `command`.
  - Pulse `command_ready` the next cycle (latency 1).
  - If `rx_data[0]`=1, go to RECV with `elem_cnt`=0 and `byte_cnt`=0. Otherwise stay in IDLE.
  - `rx_data`=0x00 is ignored: no pulse, `command` is unchanged.
- Memory select is fixed per transaction from `command[7]`: 0 → A, 1 → B. Only one `mem_we_*` is ever high.
- RECV:
  - Each `rx_ready` shifts the byte into the assembly register at position `byte_cnt`, then increments `byte_cnt`.
  - On the byte that completes an element: the next cycle, `mem_we_x`=1 for exactly one cycle, `mem_addr`=`elem_cnt`, `mem_wdata`=assembled element. `byte_cnt` is then cleared and `elem_cnt` increments.
  - After the write with `elem_cnt`=`NUM_ELEMENTOS`-1, go to DONE.
  - Bytes arriving in the same cycle as a `mem_we` pulse are accepted normally. There is no back-pressure.
- `begin_seen` is set whenever `begin_write`=1 while in RECV or DONE. Data received before `begin_write` rises is written normally.
- DONE:
  - If `begin_seen`=1 or `begin_write`=1, pulse `write_done` for one cycle and return to IDLE. Latency is 1 cycle after the last `mem_we` when `begin_write` is already high.
  - Otherwise wait in DONE. `rx_ready` in DONE is ignored.
- Timeout, when `TIMEOUT_CYCLES`>0:
  - The counter clears on each `rx_ready` and on entry to RECV, and counts up while in RECV.
  - When it reaches `TIMEOUT_CYCLES`: pulse `write_done` and `write_error` together and return to IDLE.
  - Already-written elements remain in memory; a partial element is discarded.
- `command_ready` and `write_done` are never high in the same cycle.
- Reset mid-write aborts immediately: no `write_done`, memory contents undefined for that transaction.

Test Plan:
1. IDLE, byte 0x04 → `command`=0x04, `command_ready` high for 1 cycle, 1 cycle after `rx_ready`; `busy`=0; no `mem_we`.
2. `NUM_ELEMENTOS`=4, `ELEM_BYTES`=2, `begin_write` held high.
   - Stimulus: 0x01, then 34 12 78 56 BC 9A F0 DE.
   - Required: `mem_we_a` at addr 0..3 with data 0x1234, 0x5678, 0x9ABC, 0xDEF0; each 1 cycle after the completing byte.
   - Required: `write_done` 1 cycle after the last `we`; `mem_we_b` never high.
3. Command 0x81 followed by the same data → only `mem_we_b` pulses, same addr/data; `command`=0x81.
4. `TIMEOUT_CYCLES`=100; command 0x01 then 3 bytes, then silence → `write_done`+`write_error` exactly 100 cycles after the 3rd `rx_ready`; one `we` (addr 0).
   - Then byte 0x02 → `command_ready` with `command`=0x02.
5. `reset` low mid-RECV after 2 elements → all outputs 0 asynchronously, without waiting for `clk`.
   - After release, byte 0x08 → decoded as a command, no memory write.
6. Byte 0x00 in IDLE → no `command_ready`.
   - Then 0x01 + full data with `begin_write` low → DONE waits.
   - Raise `begin_write` 50 cycles later → `write_done` the following cycle.
